// File: rtl/sub_lookahead_pipe.sv
// Pipelined A - B - bin subtractor: one SLICE-bit carry-lookahead slice per stage behind a raw
// input register, with valid/ready flow control and registered borrow/overflow/sign/zero flags.
module sub_lookahead_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_neg,
  output logic             o_zero
);

  localparam int unsigned STAGES = WIDTH / SLICE;

  // Returns {carry_out, sum}; every internal carry is a flat sum of products of G, P and cin.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= int'(SLICE); i++) begin
      term = cin;
      for (int m = 0; m < i; m++) begin
        term = term & p[m];
      end
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // Stage 0 holds the raw operands; stage s (s >= 1) holds slices 0..s-1 resolved.
  logic [STAGES:0]   r_valid;
  logic [STAGES:0]   w_adv;
  logic [STAGES:0]   w_load;
  logic              w_full;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_nb  [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_sa;
  logic [STAGES-1:0] r_sb;
  logic [WIDTH-1:0]  r_res [STAGES+1];
  logic              r_bout;
  logic              r_ovf;
  logic              r_neg;
  logic              r_zero;
  logic [SLICE:0]    w_sl;
  logic [WIDTH-1:0]  w_res [STAGES+1];
  logic [STAGES:0]   w_cout;

  // A stage is blocked only when it and every stage after it are full and the sink is not ready.
  always_comb begin
    w_adv  = '0;
    w_full = 1'b1;
    for (int s = int'(STAGES); s >= 0; s--) begin
      w_adv[s] = r_valid[s] & ~(w_full & ~i_out_ready);
      w_full   = w_full & r_valid[s];
    end
  end

  assign o_in_ready = ~r_valid[0] | w_adv[0];
  assign w_load     = {w_adv[STAGES-1:0], i_in_valid & o_in_ready};

  always_comb begin
    w_sl      = '0;
    w_res[0]  = '0;
    w_cout    = '0;
    for (int s = 1; s <= int'(STAGES); s++) begin
      w_sl = slice_add(r_a[s-1][(s-1)*SLICE +: SLICE], r_nb[s-1][(s-1)*SLICE +: SLICE],
                       r_c[s-1]);
      w_res[s]                        = r_res[s-1];
      w_res[s][(s-1)*SLICE +: SLICE]  = w_sl[SLICE-1:0];
      w_cout[s]                       = w_sl[SLICE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_c     <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        r_a[s]  <= '0;
        r_nb[s] <= '0;
      end
      for (int s = 0; s <= int'(STAGES); s++) begin
        r_res[s] <= '0;
      end
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      for (int s = 0; s <= int'(STAGES); s++) begin
        if (w_load[s]) begin
          r_valid[s] <= 1'b1;
        end else if (w_adv[s]) begin
          r_valid[s] <= 1'b0;
        end
      end
      if (w_load[0]) begin
        r_a[0]  <= i_a;
        r_nb[0] <= ~i_b;
        r_c[0]  <= ~i_bin;
        r_sa[0] <= i_a[WIDTH-1];
        r_sb[0] <= i_b[WIDTH-1];
      end
      for (int s = 1; s < int'(STAGES); s++) begin
        if (w_load[s]) begin
          r_a[s]   <= r_a[s-1];
          r_nb[s]  <= r_nb[s-1];
          r_c[s]   <= w_cout[s];
          r_sa[s]  <= r_sa[s-1];
          r_sb[s]  <= r_sb[s-1];
          r_res[s] <= w_res[s];
        end
      end
      if (w_load[STAGES]) begin
        r_res[STAGES] <= w_res[STAGES];
        r_bout        <= ~w_cout[STAGES];
        r_neg         <= w_res[STAGES][WIDTH-1];
        r_zero        <= (w_res[STAGES] == '0);
        r_ovf         <= (r_sa[STAGES-1] != r_sb[STAGES-1]) &&
                         (w_res[STAGES][WIDTH-1] != r_sa[STAGES-1]);
      end
    end
  end

  assign o_out_valid = r_valid[STAGES];
  assign o_diff      = r_res[STAGES];
  assign o_bout      = r_bout;
  assign o_ovf       = r_ovf;
  assign o_neg       = r_neg;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_sub_lookahead_pipe.sv
// Scoreboard bench for sub_lookahead_pipe: arithmetic reference model, random stimulus,
// directed corner cases, back-pressure and asynchronous reset.
module tb_sub_lookahead_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout, ovf, neg, zero;
  logic [W-1:0] diff;

  sub_lookahead_pipe #(.WIDTH(W), .SLICE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_a        (a),
    .i_b        (b),
    .i_bin      (bin),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_diff     (diff),
    .o_bout     (bout),
    .o_ovf      (ovf),
    .o_neg      (neg),
    .o_zero     (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout, ovf, neg, zero;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   stall_acc = 0;
  bit   saw_full = 0;
  bit   rnd_done = 0;

  // Plain integer arithmetic: unsigned result gives diff/borrow, signed result gives overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bi, input int acc, input bit lat);
    exp_t   e;
    longint ud, sd;
    ud     = longint'(x) - longint'(y) - longint'(bi);
    sd     = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
    e.diff = ud[W-1:0];
    e.bout = (ud < 0);
    e.ovf  = (sd < -64'sd2147483648) || (sd > 64'sd2147483647);
    e.neg  = e.diff[W-1];
    e.zero = (e.diff == '0);
    e.acc  = acc;
    e.lat  = lat;
    return e;
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom % 6)
      0: return W'($urandom % 16);
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the item.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input bit lat);
    bit done = 0;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        q.push_back(model(x, y, bi, cyc + 1, lat));
        if (!out_ready) stall_acc++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout: a=%h b=%h not accepted", x, y);
    end
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d results still expected", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every output transfer, checks hold-stability under back-pressure.
  initial begin
    exp_t         e;
    bit           hold_pend = 0;
    logic [W-1:0] h_diff = '0;
    logic [3:0]   h_fl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          tests++;
          if (!out_valid || diff !== h_diff || {bout, ovf, neg, zero} !== h_fl) begin
            fails++;
            $display("FAIL hold: valid=%b diff=%h flags=%b, expected valid=1 diff=%h flags=%b",
                     out_valid, diff, {bout, ovf, neg, zero}, h_diff, h_fl);
          end
        end
        hold_pend = out_valid && !out_ready;
        h_diff    = diff;
        h_fl      = {bout, ovf, neg, zero};
        if (in_valid && !in_ready) saw_full = 1;
        if (out_valid && out_ready) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: diff=%h with nothing expected", diff);
          end else begin
            e = q.pop_front();
            pop_cyc.push_back(cyc);
            if (diff !== e.diff || {bout, ovf, neg, zero} !== {e.bout, e.ovf, e.neg, e.zero}) begin
              fails++;
              $display("FAIL result: diff=%h bout/ovf/neg/zero=%b, expected diff=%h %b",
                       diff, {bout, ovf, neg, zero}, e.diff, {e.bout, e.ovf, e.neg, e.zero});
            end
            if (e.lat) begin
              tests++;
              if (cyc - e.acc != 4) begin
                fails++;
                $display("FAIL latency: got %0d cycles, expected 4", cyc - e.acc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] da [6] = '{32'd100, 32'd0, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0100_0000};
  logic [W-1:0] db [6] = '{32'd50, 32'd1, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd1};
  logic         dbi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, diff, bout, ovf, neg, zero}, '0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {in_ready, out_valid}, 2'b10);

    // Directed corners, one at a time with an always-ready sink.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(da[i], db[i], dbi[i], 1);
      wait_drain();
    end

    // Back-pressure: sink stalls for cycles 3..8 while 10 items stream in.
    stall_acc = 0; saw_full = 0; pop_cyc.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) drive(rv(), rv(), 1'($urandom % 2), 0);
      end
      begin
        for (int c = 1; c <= 40; c++) begin
          out_ready = !(c >= 3 && c <= 8);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("stall_accepts_le4", stall_acc <= 4, 1);
    chk("in_ready_dropped_when_full", saw_full, 1);
    chk("stall_result_count", pop_cyc.size(), 10);
    if (pop_cyc.size() == 10) chk("post_stall_throughput", pop_cyc[9] - pop_cyc[0], 9);

    // Asynchronous reset with three results in flight.
    for (int i = 0; i < 3; i++) drive(rv(), rv(), 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid, diff, bout, ovf, neg, zero}, '0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_after_reset", seen, 0);
    @(posedge clk); #1;
    drive(32'h1234_5678, 32'h0000_5678, 1'b1, 1);
    wait_drain();

    // Random stream with random gaps and random back-pressure.
    rnd_done = 0;
    fork
      begin
        logic [W-1:0] x;
        for (int i = 0; i < 300; i++) begin
          x = rv();
          drive(x, ($urandom % 6 == 0) ? x : rv(), 1'($urandom % 2), 0);
          repeat ($urandom % 3) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom % 4) != 0;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_lookahead_pipe.md
Name: sub_lookahead_pipe

Overview:
- Pipelined WIDTH-bit subtractor/comparator, the inverse operation to the team's 8-bit carry-lookahead adder.
- Computes A - B - bin one SLICE-bit lookahead slice per pipeline stage; borrow ripples between stages through registers.
- Used by the network datapath for error terms (target - output) and weight decrements.
- Valid/ready streaming on both sides; full throughput, one result per cycle.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, bits resolved per pipeline stage with full borrow lookahead inside the slice.
- Derived localparam: STAGES = WIDTH/SLICE (4 at defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers a, b, bin.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in (subtract one extra).
- out_valid  output  1  diff and flags valid.
- out_ready  input  1  downstream accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff unsigned a < b + bin.
- ovf  output  1  two's-complement overflow of the signed subtraction.
- neg  output  1  diff[WIDTH-1].
- zero  output  1  diff == 0.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0; out_valid 0; diff 0; bout, ovf, neg, zero 0. in_ready is 1 in the first cycle after reset.
- Arithmetic, per slice k: diff_k = a_k + ~b_k + c_k, with c_0 = ~bin and c_{k+1} = slice carry-out. bout = ~c_STAGES.
- Inside a slice: generate G = a & ~b, propagate P = a ^ ~b, and every internal carry uses the full two-level lookahead form, with no internal ripple.
- Stage k computes slice k only. It registers the finished low slices, the still-unprocessed high slices of a and ~b, the carry, and the operand sign bits a[W-1] and b[W-1] needed for ovf.
- Latency: an input accepted at edge N gives out_valid=1 after edge N+STAGES, when there is no stall.
- Flags are registered together with the last stage:
  - zero = (diff == 0)
  - neg = diff[W-1]
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])
- Handshake:
  - Transfer occurs when valid && ready are both high at a clock edge.
  - Stage k advances when its successor is empty or advancing. For the output stage, advancing means out_ready=1.
  - in_ready = !valid_0 || advance_0. It is combinational from out_ready through the stage chain and must not depend on in_valid.
  - When out_valid=1 and out_ready=0: diff and all flags hold stable; no stage overwrites a full stage.
  - Once asserted, out_valid stays high until the transfer completes.
- Throughput: with out_ready held high, one result per cycle and no bubbles.
- Simultaneous events: an output drain and an input accept in the same cycle, with the pipeline full, are legal. Occupancy stays constant.
- Empty pipeline: out_valid=0. diff and the flags hold their last values. They carry no meaning while out_valid=0.
- Reset mid-operation: all in-flight results are discarded. No partial result appears after rst_n deasserts.
- Inputs sampled while in_ready=0 are ignored. The upstream side holds them.

Test Plan:
- a=100, b=50, bin=0, out_ready=1 -> after 4 cycles: diff=50, bout=0, ovf=0, neg=0, zero=0.
- a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, neg=1, ovf=0, zero=0. Also a=5, b=4, bin=1 -> diff=0, zero=1, bout=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, bout=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, bout=1.
- Borrow crossing every slice: a=0x01000000, b=0x00000001 -> diff=0x00FFFFFF, bout=0.
- 10 back-to-back inputs with out_ready=0 for cycles 3-8 -> at most 4 accepted while stalled. in_ready drops to 0 when all stages are full. Results emerge in order, unchanged, none lost or duplicated. Once out_ready=1, throughput returns to 1/cycle.
- rst_n pulsed low with 3 results in flight -> out_valid=0 and all outputs 0 immediately (asynchronous). No stale results after release. The next input returns its correct result after 4 cycles.
